pin_bus_bridge: RTL and testbench
=================================

// Module: pin_bus_bridge
// PURPOSE
//   Serialises the CPU's wide memory bus over the 8-pin tiny-tapeout IO bank.
//   Sits between the cpu core and the top-level uo_out/uio_* pins.
//   Each access is sent as a framed burst of PIN_WIDTH-bit beats, with a per-beat ack and a timeout.
//   Widths are generic; the top instantiates 32/32/8.
// PARAMETERS
//   ADDRESS_WIDTH   32   CPU address width; must be a multiple of PIN_WIDTH (elaboration $error otherwise)
//   DATA_WIDTH      32   CPU data width; must be a multiple of PIN_WIDTH (elaboration $error otherwise)
//   PIN_WIDTH        8   width of the external bidirectional pin bus
//   TIMEOUT_CYCLES 255   max cycles waiting for pin_ack on one beat; 0 disables the timeout
// PORTS
//   clk             in   1     clock
//   rst_n           in   1     asynchronous active-low reset
//   req_valid       in   1     CPU request valid
//   req_ready       out  1     bridge can accept a request (IDLE only)
//   req_write       in   1     1 = write, 0 = read
//   req_address     in   AW    access address
//   req_write_data  in   DW    write data
//   resp_valid      out  1     response available; held until resp_ready
//   resp_ready      in   1     CPU consumes the response
//   resp_read_data  out  DW    read data (0 for writes or on error)
//   resp_error      out  1     access timed out
//   pin_out         out  PW    beat data driven to the pins
//   pin_oe          out  PW    all-ones while driving, all-zeros otherwise
//   pin_in          in   PW    beat data from the external device
//   pin_valid       out  1     a beat is presented or requested this cycle
//   pin_ack         in   1     device accepts/provides the beat; same clock domain, sampled directly
// BEHAVIOUR
//   Reset (asynchronous, immediate, including mid-frame): state IDLE, abandons any frame.
//     pin_out=0, pin_oe=0, pin_valid=0, resp_valid=0, resp_error=0, resp_read_data=0, counters=0.
//     req_ready=0 while rst_n=0; req_ready=1 from the first edge after release.
//   Request is captured into internal registers on req_valid&&req_ready; CPU inputs are ignored afterwards.
//   A beat completes on a clock edge with pin_valid&&pin_ack. States and transitions:
//     IDLE:  req_ready=1; on accept -> CMD.
//     CMD:   pin_out={write,0..}; the command bit is pin_out[PW-1]; pin_oe=1s. Ack -> ADDR.
//     ADDR:  AW/PW beats, least-significant first. Last ack -> WDATA if write, else TURN.
//     WDATA: DW/PW beats, LS first. Last ack -> RESP.
//     TURN:  exactly one cycle; pin_oe=0, pin_valid=0, pin_out=0 -> RDATA.
//     RDATA: pin_oe=0, pin_valid=1. Each ack captures pin_in into the next slice, LS first. Last ack -> RESP.
//     RESP:  resp_valid=1; on resp_ready -> IDLE. A new request is accepted no earlier than the next cycle.
//   pin_out=0 whenever pin_oe=0.
//   Beat counter width is $clog2(max(AW,DW)/PW+1); it clears on every state change.
//   Timeout: per-beat counter, cleared on each ack and on state entry; not active in TURN.
//     Reaching TIMEOUT_CYCLES without an ack -> RESP with resp_error=1 and resp_read_data=0.
//     An ack in the same cycle the count is reached wins: the beat completes and there is no error.
//   Latency with ack tied high and accept at edge 0:
//     write: resp_valid from cycle 10 (CMD 1, ADDR 2-5, WDATA 6-9).
//     read:  resp_valid from cycle 11 (TURN 6, RDATA 7-10).
//   With PW==AW==DW there is one beat per phase; the same FSM applies.
// STRUCTURE
//   pin_bus_pkg:
//     bridge_state_t enum {IDLE,CMD,ADDR,WDATA,TURN,RDATA,RESP}.
//     CMD_WRITE_BIT index constant.
//     beats_f(width, pin_width) function.
//   Sub-module pin_bus_shifter: PW-slice shift register.
//     Load parallel / shift out LS slice for TX; shift in PW slices for RX.
//     Used once for address+write data and once for read data.
//   FSM, beat counter and timeout counter live in pin_bus_bridge.
// TESTING
//   1 Write A=0x12345678, D=0xCAFEBABE, ack tied high:
//     pin_out 0x80,78,56,34,12,BE,BA,FE,CA on cycles 1-9; resp_valid at cycle 10, error=0.
//   2 Read A=0x00000010, device returns 0xDEADBEEF:
//     pin_oe=0 from cycle 6; resp_read_data=0xDEADBEEF at cycle 11.
//   3 Ack delayed 3 cycles on every beat of a write:
//     each beat is held stable until ack; resp_valid at cycle 37, no error.
//   4 TIMEOUT_CYCLES=4, no ack during ADDR beat 2:
//     RESP with resp_error=1 and read_data=0 after 4 idle cycles; next request works normally.
//   5 rst_n pulsed low during WDATA:
//     pin_oe, pin_valid and resp_valid drop to 0 in the same cycle; req_ready=1 on the first edge after release.
//   6 resp_ready held low 5 cycles, req_valid held high:
//     resp_valid held and req_ready=0 throughout; the next request is accepted one cycle after the handshake.

Source files
------------

// File: rtl/pin_bus_pkg.sv
// Shared types and helpers for the pin bus bridge.
// Beat states, command-beat layout and beat-count helper.
package pin_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        WDATA,
        TURN,
        RDATA,
        RESP
    } bridge_state_t;

    // Write flag position in the command beat, counted down from its MSB.
    localparam int CMD_WRITE_BIT = 0;

    // Number of pin-width beats needed to carry a field of the given width.
    function automatic int beats_f(input int width, input int pin_width);
        return width / pin_width;
    endfunction

endpackage

// File: rtl/pin_bus_shifter.sv
// Slice-wide shift register for the pin bus bridge.
// Parallel load, then shift right by one pin slice per beat.
module pin_bus_shifter #(
    parameter int WIDTH     = 64,
    parameter int PIN_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic [WIDTH-1:0]     load_data_i,
    input  logic                 shift_i,
    input  logic [PIN_WIDTH-1:0] shift_in_i,
    output logic [WIDTH-1:0]     data_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] shifted;

    // New slices enter at the top so the first beat ends up least significant.
    generate
        if (WIDTH > PIN_WIDTH) begin : g_wide
            assign shifted = {shift_in_i, data_q[WIDTH-1:PIN_WIDTH]};
        end else begin : g_narrow
            assign shifted = shift_in_i;
        end
    endgenerate

    // Load has priority over shift.
    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = load_data_i;
        end else if (shift_i) begin
            data_d = shifted;
        end
    end

    // Shift register storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/pin_bus_bridge.sv
// CPU bus to narrow pin bus bridge.
// Sends each access as CMD/ADDR/WDATA or CMD/ADDR/TURN/RDATA beats.
module pin_bus_bridge
    import pin_bus_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int PIN_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [ADDRESS_WIDTH-1:0] req_address,
    input  logic [DATA_WIDTH-1:0]    req_write_data,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [DATA_WIDTH-1:0]    resp_read_data,
    output logic                     resp_error,
    output logic [PIN_WIDTH-1:0]     pin_out,
    output logic [PIN_WIDTH-1:0]     pin_oe,
    input  logic [PIN_WIDTH-1:0]     pin_in,
    output logic                     pin_valid,
    input  logic                     pin_ack
);

    localparam int AW        = ADDRESS_WIDTH;
    localparam int DW        = DATA_WIDTH;
    localparam int PW        = PIN_WIDTH;
    localparam int A_BEATS   = beats_f(AW, PW);
    localparam int D_BEATS   = beats_f(DW, PW);
    localparam int MAX_BEATS = (A_BEATS > D_BEATS) ? A_BEATS : D_BEATS;
    localparam int BW        = $clog2(MAX_BEATS + 1);
    localparam int TW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int WR_BIT    = PW - 1 - CMD_WRITE_BIT;
    localparam bit TO_EN     = (TIMEOUT_CYCLES != 0);

    localparam logic [BW-1:0] A_LAST = BW'(A_BEATS - 1);
    localparam logic [BW-1:0] D_LAST = BW'(D_BEATS - 1);
    localparam logic [TW-1:0] TO_LAST =
        TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    generate
        if ((AW % PW) != 0) begin : g_bad_aw
            $error("ADDRESS_WIDTH must be a multiple of PIN_WIDTH");
        end
        if ((DW % PW) != 0) begin : g_bad_dw
            $error("DATA_WIDTH must be a multiple of PIN_WIDTH");
        end
    endgenerate

    bridge_state_t state_q, state_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [TW-1:0] to_q, to_d;
    logic          err_q, err_d;
    logic          write_q;
    logic          rdy_q;

    logic          accept;
    logic          beat_done;
    logic          timeout;
    logic          drive;
    logic          tx_shift;
    logic          rx_shift;
    logic [PW-1:0] cmd_beat;
    logic [PW-1:0] tx_slice;
    logic          unused_tx_hi;

    logic [AW+DW-1:0] tx_data;
    logic [DW-1:0]    rx_data;

    assign accept    = req_valid && req_ready;
    assign beat_done = pin_valid && pin_ack;
    assign drive     = (state_q == CMD) || (state_q == ADDR)
                    || (state_q == WDATA);
    assign tx_shift  = beat_done && ((state_q == ADDR)
                    || (state_q == WDATA));
    assign rx_shift  = beat_done && (state_q == RDATA);
    assign timeout   = TO_EN && pin_valid && !pin_ack
                    && (to_q == TO_LAST);

    assign tx_slice     = tx_data[PW-1:0];
    assign unused_tx_hi = ^tx_data[AW+DW-1:PW];

    always_comb begin
        cmd_beat         = '0;
        cmd_beat[WR_BIT] = write_q;
    end

    pin_bus_shifter #(
        .WIDTH     (AW + DW),
        .PIN_WIDTH (PW)
    ) u_tx (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (accept),
        .load_data_i ({req_write_data, req_address}),
        .shift_i     (tx_shift),
        .shift_in_i  ('0),
        .data_o      (tx_data)
    );

    pin_bus_shifter #(
        .WIDTH     (DW),
        .PIN_WIDTH (PW)
    ) u_rx (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (accept),
        .load_data_i ('0),
        .shift_i     (rx_shift),
        .shift_in_i  (pin_in),
        .data_o      (rx_data)
    );

    // Pin and response outputs decoded from the current state.
    always_comb begin
        pin_out        = '0;
        pin_oe         = '0;
        pin_valid      = 1'b0;
        resp_valid     = 1'b0;
        resp_error     = 1'b0;
        resp_read_data = '0;
        req_ready      = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = rdy_q;
            end
            CMD: begin
                pin_out   = cmd_beat;
                pin_oe    = '1;
                pin_valid = 1'b1;
            end
            ADDR, WDATA: begin
                pin_out   = tx_slice;
                pin_oe    = '1;
                pin_valid = 1'b1;
            end
            RDATA: begin
                pin_valid = 1'b1;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_error = err_q;
                if (!err_q && !write_q) begin
                    resp_read_data = rx_data;
                end
            end
            default: begin
            end
        endcase
        if (!drive) begin
            pin_out = '0;
        end
    end

    // Next state, beat count and per-beat timeout.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        to_d    = to_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = CMD;
                    err_d   = 1'b0;
                end
            end
            CMD: begin
                if (beat_done) begin
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (beat_done) begin
                    if (beat_q == A_LAST) begin
                        state_d = write_q ? WDATA : TURN;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            WDATA: begin
                if (beat_done) begin
                    if (beat_q == D_LAST) begin
                        state_d = RESP;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            TURN: begin
                state_d = RDATA;
            end
            RDATA: begin
                if (beat_done) begin
                    if (beat_q == D_LAST) begin
                        state_d = RESP;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (TO_EN && pin_valid) begin
            to_d = beat_done ? '0 : to_q + 1'b1;
        end
        if (timeout) begin
            state_d = RESP;
            err_d   = 1'b1;
        end
        if (state_d != state_q) begin
            beat_d = '0;
            to_d   = '0;
        end
    end

    // State and counter registers; reset abandons any frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            to_q    <= '0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            to_q    <= to_d;
            err_q   <= err_d;
            rdy_q   <= 1'b1;
        end
    end

    // Request direction captured on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q <= 1'b0;
        end else if (accept) begin
            write_q <= req_write;
        end
    end

endmodule

// File: tb/tb_pin_bus_bridge.sv
// Directed self-checking bench for pin_bus_bridge.
// Timeout is set to 4 cycles so the boundary is reachable quickly.
module tb_pin_bus_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_address = '0;
    logic [31:0] req_write_data = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_read_data;
    logic        resp_error;
    logic [7:0]  pin_out;
    logic [7:0]  pin_oe;
    logic [7:0]  pin_in = '0;
    logic        pin_valid;
    logic        pin_ack = 1'b0;

    int checks = 0;
    int errors = 0;

    pin_bus_bridge #(
        .ADDRESS_WIDTH  (32),
        .DATA_WIDTH     (32),
        .PIN_WIDTH      (8),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_address    (req_address),
        .req_write_data (req_write_data),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_read_data (resp_read_data),
        .resp_error     (resp_error),
        .pin_out        (pin_out),
        .pin_oe         (pin_oe),
        .pin_in         (pin_in),
        .pin_valid      (pin_valid),
        .pin_ack        (pin_ack)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if ({pin_out, pin_oe, pin_valid} !== 17'h0) begin
            errors++;
            $display("FAIL reset_pins got %h/%h/%b want 0/0/0",
                     pin_out, pin_oe, pin_valid);
        end
        checks++;
        if ({resp_valid, resp_error, resp_read_data} !== 34'h0) begin
            errors++;
            $display("FAIL reset_resp got %b/%b/%h want 0/0/0",
                     resp_valid, resp_error, resp_read_data);
        end
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_low got %b want 0", req_ready);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge got %b want 0", req_ready);
        end
        step();
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_edge got %b want 1", req_ready);
        end
    endtask

    task automatic test_write();
        logic [7:0] exp [0:8];
        exp = '{8'h80, 8'h78, 8'h56, 8'h34, 8'h12,
                8'hBE, 8'hBA, 8'hFE, 8'hCA};
        req_write      = 1'b1;
        req_address    = 32'h1234_5678;
        req_write_data = 32'hCAFE_BABE;
        req_valid      = 1'b1;
        pin_ack        = 1'b1;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            checks++;
            if ({pin_out, pin_oe, pin_valid, resp_valid}
                    !== {exp[i], 8'hFF, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL write_beat%0d got %h/%h/%b/%b want %h/ff/1/0",
                         i, pin_out, pin_oe, pin_valid, resp_valid, exp[i]);
            end
            step();
        end
        checks++;
        if ({resp_valid, resp_error, resp_read_data} !== {2'b10, 32'h0}) begin
            errors++;
            $display("FAIL write_resp got %b/%b/%h want 1/0/0",
                     resp_valid, resp_error, resp_read_data);
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        checks++;
        if ({resp_valid, req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL write_done got %b/%b want 0/1",
                     resp_valid, req_ready);
        end
    endtask

    task automatic test_read(input logic [31:0] addr,
                             input logic [31:0] data);
        logic [16:0] exp;
        req_write   = 1'b0;
        req_address = addr;
        req_valid   = 1'b1;
        pin_ack     = 1'b1;
        step();
        req_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (c >= 7) begin
                pin_in = data[8*(c-7) +: 8];
            end
            if (c == 1) begin
                exp = {8'h00, 8'hFF, 1'b1};
            end else if (c <= 5) begin
                exp = {addr[8*(c-2) +: 8], 8'hFF, 1'b1};
            end else if (c == 6) begin
                exp = 17'h0;
            end else begin
                exp = {8'h00, 8'h00, 1'b1};
            end
            checks++;
            if ({pin_out, pin_oe, pin_valid} !== exp) begin
                errors++;
                $display("FAIL read_cycle%0d got %h/%h/%b want %h",
                         c, pin_out, pin_oe, pin_valid, exp);
            end
            step();
        end
        checks++;
        if ({resp_valid, resp_error, resp_read_data} !== {2'b10, data}) begin
            errors++;
            $display("FAIL read_resp got %b/%b/%h want 1/0/%h",
                     resp_valid, resp_error, resp_read_data, data);
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
    endtask

    task automatic test_ack_delay();
        logic [7:0] exp [0:8];
        exp = '{8'h80, 8'h0F, 8'h0F, 8'hA5, 8'hA5,
                8'h44, 8'h33, 8'h22, 8'h11};
        req_write      = 1'b1;
        req_address    = 32'hA5A5_0F0F;
        req_write_data = 32'h1122_3344;
        req_valid      = 1'b1;
        pin_ack        = 1'b0;
        step();
        req_valid = 1'b0;
        for (int b = 0; b < 9; b++) begin
            for (int w = 0; w < 4; w++) begin
                pin_ack = (w == 3);
                checks++;
                if ({pin_out, pin_valid, resp_valid}
                        !== {exp[b], 1'b1, 1'b0}) begin
                    errors++;
                    $display("FAIL delay_b%0d_w%0d got %h/%b/%b want %h/1/0",
                             b, w, pin_out, pin_valid, resp_valid, exp[b]);
                end
                step();
            end
        end
        pin_ack = 1'b0;
        checks++;
        if ({resp_valid, resp_error} !== 2'b10) begin
            errors++;
            $display("FAIL delay_resp got %b/%b want 1/0",
                     resp_valid, resp_error);
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
    endtask

    task automatic test_timeout();
        req_write   = 1'b0;
        req_address = 32'h0000_AB04;
        req_valid   = 1'b1;
        pin_ack     = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        step();
        pin_ack = 1'b0;
        for (int c = 3; c <= 6; c++) begin
            checks++;
            if ({pin_out, pin_valid, resp_valid} !== {8'hAB, 2'b10}) begin
                errors++;
                $display("FAIL stall_cycle%0d got %h/%b/%b want ab/1/0",
                         c, pin_out, pin_valid, resp_valid);
            end
            step();
        end
        checks++;
        if ({resp_valid, resp_error, resp_read_data} !== {2'b11, 32'h0}) begin
            errors++;
            $display("FAIL timeout_resp got %b/%b/%h want 1/1/0",
                     resp_valid, resp_error, resp_read_data);
        end
        checks++;
        if ({pin_oe, pin_valid} !== 9'h0) begin
            errors++;
            $display("FAIL timeout_pins got %h/%b want 0/0",
                     pin_oe, pin_valid);
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        test_read(32'h0000_0040, 32'h1357_9BDF);
    endtask

    task automatic test_reset_mid();
        req_write      = 1'b1;
        req_address    = 32'h0000_0001;
        req_write_data = 32'h0000_0002;
        req_valid      = 1'b1;
        pin_ack        = 1'b1;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
        end
        checks++;
        if ({pin_valid, pin_oe} !== 9'h1FF) begin
            errors++;
            $display("FAIL mid_frame got %b/%h want 1/ff", pin_valid, pin_oe);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({pin_out, pin_oe, pin_valid, resp_valid, req_ready} !== 19'h0) begin
            errors++;
            $display("FAIL async_reset got %h/%h/%b/%b/%b want all 0",
                     pin_out, pin_oe, pin_valid, resp_valid, req_ready);
        end
        pin_ack = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_ready_early got %b want 0", req_ready);
        end
        step();
        checks++;
        if ({req_ready, pin_valid} !== 2'b10) begin
            errors++;
            $display("FAIL mid_ready_after got %b/%b want 1/0",
                     req_ready, pin_valid);
        end
    endtask

    task automatic test_back_to_back();
        bit seen;
        req_write      = 1'b1;
        req_address    = 32'h0000_0100;
        req_write_data = 32'h0;
        req_valid      = 1'b1;
        pin_ack        = 1'b1;
        step();
        req_write   = 1'b0;
        req_address = 32'h0000_0020;
        for (int i = 0; i < 9; i++) begin
            step();
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({resp_valid, req_ready} !== 2'b10) begin
                errors++;
                $display("FAIL hold_cycle%0d got %b/%b want 1/0",
                         i, resp_valid, req_ready);
            end
            step();
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        checks++;
        if ({resp_valid, req_ready, pin_valid} !== 3'b010) begin
            errors++;
            $display("FAIL after_handshake got %b/%b/%b want 0/1/0",
                     resp_valid, req_ready, pin_valid);
        end
        step();
        req_valid = 1'b0;
        checks++;
        if ({pin_out, pin_oe, pin_valid} !== {8'h00, 8'hFF, 1'b1}) begin
            errors++;
            $display("FAIL next_cmd got %h/%h/%b want 00/ff/1",
                     pin_out, pin_oe, pin_valid);
        end
        pin_in = 8'h5A;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            seen = resp_valid;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL next_read_wait got no resp want resp_valid");
        end else if (resp_read_data !== 32'h5A5A_5A5A) begin
            errors++;
            $display("FAIL next_read_data got %h want 5a5a5a5a",
                     resp_read_data);
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        pin_ack    = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read(32'h0000_0010, 32'hDEAD_BEEF);
        test_ack_delay();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
